// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter shared types: opcodes, FSM states, counter width.
// Imported by alu_arbiter, alu_grant and the bench.
package alu_arbiter_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_MUL = 3'b011,
    OP_SUB = 3'b110
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  localparam int CNT_W = 4;

  function automatic logic is_mul(logic [2:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter request/response bundle for two requesters.
// slave = arbiter side, master = requester side.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  req0_valid_i;
  logic                  req0_ready_o;
  logic [2:0]            req0_op_i;
  logic [DATA_WIDTH-1:0] req0_a_i;
  logic [DATA_WIDTH-1:0] req0_b_i;

  logic                  req1_valid_i;
  logic                  req1_ready_o;
  logic [2:0]            req1_op_i;
  logic [DATA_WIDTH-1:0] req1_a_i;
  logic [DATA_WIDTH-1:0] req1_b_i;

  logic                  rsp0_valid_o;
  logic                  rsp0_ready_i;
  logic                  rsp1_valid_o;
  logic                  rsp1_ready_i;
  logic [DATA_WIDTH-1:0] rsp_data_o;
  logic                  rsp_err_o;
  logic                  busy_o;

  modport slave (
    input  req0_valid_i, req0_op_i,
    input  req0_a_i, req0_b_i,
    output req0_ready_o,
    input  req1_valid_i, req1_op_i,
    input  req1_a_i, req1_b_i,
    output req1_ready_o,
    output rsp0_valid_o, rsp1_valid_o,
    input  rsp0_ready_i, rsp1_ready_i,
    output rsp_data_o, rsp_err_o,
    output busy_o
  );

  modport master (
    output req0_valid_i, req0_op_i,
    output req0_a_i, req0_b_i,
    input  req0_ready_o,
    output req1_valid_i, req1_op_i,
    output req1_a_i, req1_b_i,
    input  req1_ready_o,
    input  rsp0_valid_o, rsp1_valid_o,
    output rsp0_ready_i, rsp1_ready_i,
    input  rsp_data_o, rsp_err_o,
    input  busy_o
  );

endinterface

// File: rtl/alu_grant.sv
// Two-way grant: fixed priority (req0 wins) by default,
// round-robin when ALU_ARBITER_RR_EN is defined.
module alu_grant
  import alu_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic hs_i,
  output logic gnt0_o,
  output logic gnt1_o
);

`ifdef ALU_ARBITER_RR_EN
  logic last_q;
  logic last_d;

  // On contention, favour the requester not served last.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (en_i) begin
      if (valid0_i && valid1_i) begin
        gnt0_o = last_q;
        gnt1_o = ~last_q;
      end else begin
        gnt0_o = valid0_i;
        gnt1_o = valid1_i;
      end
    end
  end

  assign last_d = hs_i ? gnt1_o : last_q;

  // Pointer remembers who won the last handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk_i, rst_i, hs_i};

  // Fixed priority: requester 0 always wins.
  always_comb begin
    gnt0_o = en_i & valid0_i;
    gnt1_o = en_i & valid1_i & ~valid0_i;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester shared ALU with IDLE/EXEC/RESP FSM.
// Build option: ALU_ARBITER_RR_EN selects round-robin grant.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_arbiter_if.slave  bus
);

  state_e                state_q;
  logic                  owner_q;
  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic                  rsp0_q;
  logic                  rsp1_q;

  logic                  gnt0;
  logic                  gnt1;
  logic                  hs;
  logic                  idle_en;
  logic [2:0]            sel_op;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [CNT_W-1:0]      cnt_d;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_err;
  logic                  rsp_done;

  assign idle_en = (state_q == ST_IDLE) & ~rst_i;

  alu_grant u_grant (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (idle_en),
    .valid0_i (bus.req0_valid_i),
    .valid1_i (bus.req1_valid_i),
    .hs_i     (hs),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1)
  );

  assign bus.req0_ready_o = gnt0;
  assign bus.req1_ready_o = gnt1;

  assign hs = (bus.req0_valid_i & gnt0)
            | (bus.req1_valid_i & gnt1);

  assign sel_op = gnt1 ? bus.req1_op_i : bus.req0_op_i;
  assign sel_a  = gnt1 ? bus.req1_a_i  : bus.req0_a_i;
  assign sel_b  = gnt1 ? bus.req1_b_i  : bus.req0_b_i;

  assign cnt_d = is_mul(sel_op)
               ? CNT_W'(MUL_CYCLES - 1)
               : '0;

  // ALU on the captured operands; unknown opcodes flag an error.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    unique case (op_q)
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_MUL:  alu_res = a_q * b_q;
      default: alu_err = 1'b1;
    endcase
  end

  assign rsp_done = (rsp0_q & bus.rsp0_ready_i)
                  | (rsp1_q & bus.rsp1_ready_i);

  // Main FSM: capture on handshake, execute, hold response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (hs) begin
            owner_q <= gnt1;
            op_q    <= sel_op;
            a_q     <= sel_a;
            b_q     <= sel_b;
            cnt_q   <= cnt_d;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q == '0) begin
            data_q  <= alu_res;
            err_q   <= alu_err;
            rsp0_q  <= ~owner_q;
            rsp1_q  <= owner_q;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_done) begin
            rsp0_q  <= 1'b0;
            rsp1_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp0_valid_o = rsp0_q;
  assign bus.rsp1_valid_o = rsp1_q;
  assign bus.rsp_data_o   = data_q;
  assign bus.rsp_err_o    = err_q;
  assign bus.busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
// Honours ALU_ARBITER_RR_EN for the contention expectations.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(32)) bus();

  alu_arbiter #(
    .DATA_WIDTH (32),
    .MUL_CYCLES (3)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int          r;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] d;
    logic        e;
  } vec_t;

  task automatic idle_inputs();
    bus.req0_valid_i = 1'b0;
    bus.req0_op_i    = 3'b000;
    bus.req0_a_i     = '0;
    bus.req0_b_i     = '0;
    bus.req1_valid_i = 1'b0;
    bus.req1_op_i    = 3'b000;
    bus.req1_a_i     = '0;
    bus.req1_b_i     = '0;
    bus.rsp0_ready_i = 1'b1;
    bus.rsp1_ready_i = 1'b1;
  endtask

  task automatic drive(input int r, input logic v,
                       input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    if (r == 0) begin
      bus.req0_valid_i = v;
      bus.req0_op_i    = op;
      bus.req0_a_i     = a;
      bus.req0_b_i     = b;
    end else begin
      bus.req1_valid_i = v;
      bus.req1_op_i    = op;
      bus.req1_a_i     = a;
      bus.req1_b_i     = b;
    end
  endtask

  // Offer an op, wait (bounded) for ready, then scramble inputs.
  task automatic send(input int r, input logic [2:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      output bit ok);
    ok = 1'b0;
    drive(r, 1'b1, op, a, b);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((r == 0 && bus.req0_ready_o) ||
          (r == 1 && bus.req1_ready_o)) begin
        ok = 1'b1;
        break;
      end
      if (i < 19) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    drive(r, 1'b0, 3'b111, ~a, 32'hDEAD_BEEF);
  endtask

  // Cycles from handshake until rsp valid; -1 on timeout.
  task automatic wait_rsp(input int r, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((r == 0 && bus.rsp0_valid_o) ||
          (r == 1 && bus.rsp1_valid_o)) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset busy: got %b exp 0", bus.busy_o);
    end
    checks++;
    if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset ready: got %b%b exp 00",
               bus.req0_ready_o, bus.req1_ready_o);
    end
    checks++;
    if ({bus.rsp0_valid_o, bus.rsp1_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset rsp_valid: got %b%b exp 00",
               bus.rsp0_valid_o, bus.rsp1_valid_o);
    end
    checks++;
    if (bus.rsp_data_o !== 32'h0 || bus.rsp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset data/err: got %h/%b exp 0/0",
               bus.rsp_data_o, bus.rsp_err_o);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_ops();
    vec_t v[12];
    bit   ok;
    int   lat;
    v[0]  = '{0, OP_ADD, 32'd5, 32'd7, 2, 32'd12, 1'b0};
    v[1]  = '{1, OP_SUB, 32'd0, 32'd1, 2, 32'hFFFF_FFFF, 1'b0};
    v[2]  = '{1, OP_MUL, 32'h1_0000, 32'h1_0000, 4, 32'h0, 1'b0};
    v[3]  = '{0, OP_AND, 32'hF0F0, 32'hFF00, 2, 32'hF000, 1'b0};
    v[4]  = '{1, OP_OR,  32'hF0F0, 32'hFF00, 2, 32'hFFF0, 1'b0};
    v[5]  = '{0, OP_MUL, 32'd7, 32'd6, 4, 32'd42, 1'b0};
    v[6]  = '{0, OP_ADD, 32'hFFFF_FFFF, 32'd2, 2, 32'd1, 1'b0};
    v[7]  = '{1, OP_MUL, 32'hFFFF_FFFF, 32'd2, 4, 32'hFFFF_FFFE, 1'b0};
    v[8]  = '{0, OP_SUB, 32'd10, 32'd3, 2, 32'd7, 1'b0};
    v[9]  = '{1, 3'b111, 32'd5, 32'd5, 2, 32'h0, 1'b1};
    v[10] = '{0, 3'b100, 32'd9, 32'd9, 2, 32'h0, 1'b1};
    v[11] = '{0, OP_ADD, 32'd1, 32'd1, 2, 32'd2, 1'b0};
    foreach (v[k]) begin
      send(v[k].r, v[k].op, v[k].a, v[k].b, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL ops[%0d] handshake: no ready", k);
      end
      wait_rsp(v[k].r, lat);
      checks++;
      if (lat != v[k].lat) begin
        errors++;
        $display("FAIL ops[%0d] latency: got %0d exp %0d",
                 k, lat, v[k].lat);
      end
      checks++;
      if (bus.rsp_data_o !== v[k].d) begin
        errors++;
        $display("FAIL ops[%0d] data: got %h exp %h",
                 k, bus.rsp_data_o, v[k].d);
      end
      checks++;
      if (bus.rsp_err_o !== v[k].e) begin
        errors++;
        $display("FAIL ops[%0d] err: got %b exp %b",
                 k, bus.rsp_err_o, v[k].e);
      end
      checks++;
      if ((v[k].r == 0 && bus.rsp1_valid_o !== 1'b0) ||
          (v[k].r == 1 && bus.rsp0_valid_o !== 1'b0)) begin
        errors++;
        $display("FAIL ops[%0d] other rsp_valid: got 1 exp 0", k);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_hold();
    bit ok;
    int lat;
    bus.rsp0_ready_i = 1'b0;
    send(0, OP_ADD, 32'd3, 32'd4, ok);
    wait_rsp(0, lat);
    checks++;
    if (!ok || lat != 2) begin
      errors++;
      $display("FAIL hold first rsp: got ok=%0b lat=%0d exp 1/2",
               ok, lat);
    end
    drive(1, 1'b1, OP_OR, 32'd1, 32'd2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (bus.rsp0_valid_o !== 1'b1 ||
          bus.rsp_data_o !== 32'd7 ||
          bus.rsp_err_o !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] rsp: got v=%b d=%h e=%b exp 1/7/0",
                 k, bus.rsp0_valid_o, bus.rsp_data_o,
                 bus.rsp_err_o);
      end
      checks++;
      if (bus.req1_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] req1_ready: got 1 exp 0", k);
      end
    end
    bus.rsp0_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.req1_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL hold release-cycle req1_ready: got 1 exp 0");
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.req1_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL hold idle: got ready1=%b busy=%b exp 1/0",
               bus.req1_ready_o, bus.busy_o);
    end
    @(posedge clk);
    #1;
    drive(1, 1'b0, 3'b000, '0, '0);
    wait_rsp(1, lat);
    checks++;
    if (lat != 2 || bus.rsp_data_o !== 32'd3) begin
      errors++;
      $display("FAIL hold queued req1: got lat=%0d d=%h exp 2/3",
               lat, bus.rsp_data_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_contention();
    int exp_g[4];
    int g;
    int lat;
`ifdef ALU_ARBITER_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    do_reset();
    drive(0, 1'b1, OP_ADD, 32'd10, 32'd1);
    drive(1, 1'b1, OP_SUB, 32'd20, 32'd2);
    for (int n = 0; n < 4; n++) begin
      g = -1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.req0_ready_o && bus.req1_ready_o) begin
          checks++;
          errors++;
          $display("FAIL contention[%0d] both ready: got 11 exp one", n);
        end
        if (bus.req0_ready_o) begin
          g = 0;
          break;
        end
        if (bus.req1_ready_o) begin
          g = 1;
          break;
        end
        @(posedge clk);
        #1;
      end
      checks++;
      if (g != exp_g[n]) begin
        errors++;
        $display("FAIL contention[%0d] grant: got %0d exp %0d",
                 n, g, exp_g[n]);
      end
      @(posedge clk);
      #1;
      if (g >= 0) begin
        wait_rsp(g, lat);
        checks++;
        if (lat != 2 ||
            bus.rsp_data_o !== ((g == 0) ? 32'd11 : 32'd18)) begin
          errors++;
          $display("FAIL contention[%0d] rsp: got lat=%0d d=%h exp 2/%h",
                   n, lat, bus.rsp_data_o,
                   (g == 0) ? 32'd11 : 32'd18);
        end
        @(posedge clk);
        #1;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_mul();
    bit ok;
    bit seen;
    int lat;
    send(0, OP_MUL, 32'd3, 32'd3, ok);
    @(posedge clk);
    #1;
    checks++;
    if (!ok || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL midmul start: got ok=%0b busy=%b exp 1/1",
               ok, bus.busy_o);
    end
    rst = 1'b1;
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 ||
        bus.rsp0_valid_o !== 1'b0 || bus.rsp1_valid_o !== 1'b0 ||
        bus.rsp_data_o !== 32'h0 || bus.rsp_err_o !== 1'b0 ||
        bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midmul reset outputs: got b=%b v=%b%b d=%h e=%b r=%b%b exp all 0",
               bus.busy_o, bus.rsp0_valid_o, bus.rsp1_valid_o,
               bus.rsp_data_o, bus.rsp_err_o,
               bus.req0_ready_o, bus.req1_ready_o);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.rsp0_valid_o || bus.rsp1_valid_o || bus.busy_o)
        seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midmul stale response: got activity exp none");
    end
    @(posedge clk);
    #1;
    drive(0, 1'b1, OP_OR, 32'd8, 32'd1);
    drive(1, 1'b1, OP_ADD, 32'd4, 32'd4);
    @(negedge clk);
    checks++;
    if (bus.req0_ready_o !== 1'b1 || bus.req1_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midmul post grant: got %b%b exp 10",
               bus.req0_ready_o, bus.req1_ready_o);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    wait_rsp(0, lat);
    checks++;
    if (lat != 2 || bus.rsp_data_o !== 32'd9 ||
        bus.rsp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL midmul post rsp: got lat=%0d d=%h e=%b exp 2/9/0",
               lat, bus.rsp_data_o, bus.rsp_err_o);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alu_ops();
    test_hold();
    test_contention();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set operand and result width.
REQ-002 Parameter MUL_CYCLES, default 3, SHALL set EXEC-state cycles for MUL (legal range 1..15).
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 reqN_valid_i  input  1 (N=0,1)  SHALL indicate requester N offers an operation.
REQ-006 reqN_ready_o  output  1  SHALL indicate the block accepts requester N's operation this cycle.
REQ-007 reqN_op_i  input  3  SHALL carry the opcode.
REQ-008 reqN_a_i, reqN_b_i  input  DATA_WIDTH  SHALL carry the operands.
REQ-009 rspN_valid_o  output  1  SHALL indicate a result for requester N.
REQ-010 rspN_ready_i  input  1  SHALL indicate requester N consumes the result.
REQ-011 rsp_data_o  output  DATA_WIDTH  SHALL carry the result, shared by both responders.
REQ-012 rsp_err_o  output  1  SHALL flag an illegal opcode, qualified by either rspN_valid_o.
REQ-013 busy_o  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-014 FSM SHALL have states IDLE, EXEC, RESP.
REQ-015 In IDLE, reqN_ready_o SHALL be combinationally high only for the granted requester with reqN_valid_i high; never both.
REQ-016 A handshake (valid&ready) SHALL capture op, a, b and owner id, and move IDLE->EXEC.
REQ-017 Opcodes SHALL be 000 AND, 001 OR, 010 ADD, 110 SUB, 011 MUL.
REQ-018 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH; MUL SHALL return the low DATA_WIDTH bits of the unsigned product.
REQ-019 Non-MUL ops SHALL stay one cycle in EXEC; MUL SHALL stay MUL_CYCLES cycles, counted by a down-counter loaded on handshake.
REQ-020 Leaving EXEC SHALL register result into rsp_data_o and move to RESP.
REQ-021 Illegal opcode SHALL produce rsp_data_o=0, rsp_err_o=1, one EXEC cycle.
REQ-022 In RESP, rspN_valid_o of owner only SHALL be high; rsp_data_o and rsp_err_o SHALL hold stable until rspN_ready_i.
REQ-023 rspN_valid_o & rspN_ready_i SHALL move RESP->IDLE; no new grant in that same cycle.
REQ-024 Latency: handshake in cycle T SHALL give rspN_valid_o first high in cycle T+2 (non-MUL) or T+1+MUL_CYCLES (MUL).
REQ-025 Requests arriving outside IDLE SHALL see ready low and SHALL be held by the requester (no drop, no queue).
REQ-026 Operand changes after handshake SHALL NOT affect the in-flight result.

Reset
REQ-027 rst_i high SHALL force IDLE, both ready and rsp valid outputs low, rsp_data_o=0, rsp_err_o=0, busy_o=0, counter=0, round-robin pointer to "last granted = 1".
REQ-028 Reset during EXEC or RESP SHALL discard the operation; no response SHALL ever be issued for it.

Configuration
REQ-029 Macro ALU_ARBITER_RR_EN defined: when both valid in IDLE, grant SHALL go to the requester not granted last; pointer updates on each handshake.
REQ-030 Macro absent: requester 0 SHALL always win contention; pointer logic SHALL not exist.

Structure
REQ-031 Shared package SHALL hold opcode constants (AND, OR, ADD, SUB, MUL) and the FSM state enum.
REQ-032 Sub-module alu_grant SHALL implement the two-way grant (fixed or round-robin) with handshake-driven pointer update.

Verification
REQ-033 Req0 ADD a=5,b=7, rsp0_ready_i=1 -> rsp0_valid_o at T+2, rsp_data_o=12, rsp_err_o=0.
REQ-034 Req1 SUB a=0,b=1 -> rsp_data_o=0xFFFFFFFF; req1 MUL a=0x10000,b=0x10000 with MUL_CYCLES=3 -> rsp at T+4, data=0.
REQ-035 Both valid continuously, RR enabled, 4 ops -> grants 0,1,0,1; without macro -> grants 0,0,0,0.
REQ-036 rsp0_ready_i low 5 cycles in RESP -> rsp0_valid_o, data held stable; req1 ready stays low throughout.
REQ-037 Opcode 111 -> rsp_data_o=0, rsp_err_o=1 at T+2.
REQ-038 rst_i pulsed mid-MUL -> outputs at reset values immediately; no rsp_valid afterward; next request serviced normally, req0 first.
